// File: rtl/joy_sar_scan.sv
// Four-channel joystick SAR scanner: steps a 6-bit DAC against a registered comparator and publishes all four results at once.
// Optional free-running mode is enabled by defining JOY_SCAN_AUTO_EN.
module joy_sar_scan #(
    parameter int SETTLE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       hilo,
    output logic [5:0] dac,
    output logic       selb,
    output logic       sela,
    output logic [5:0] joy0,
    output logic [5:0] joy1,
    output logic [5:0] joy2,
    output logic [5:0] joy3,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] TRIAL = 2'd1;
    localparam logic [1:0] STORE = 2'd2;

    localparam logic [7:0] LAST = 8'(SETTLE - 1);

`ifdef JOY_SCAN_AUTO_EN
    localparam logic AUTO = 1'b1;
`else
    localparam logic AUTO = 1'b0;
`endif

    logic [1:0] state;
    logic [7:0] cnt;
    logic [2:0] bitn;
    logic [5:0] code;
    logic [1:0] ch;
    logic [5:0] shadow [0:3];
    logic [5:0] kept;
    logic       go;

    function automatic logic [5:0] bitmask(input logic [2:0] b);
        return 6'd1 << b;
    endfunction

    // The trial code currently on the DAC, with the tested bit dropped if the axis is not above it
    assign kept = hilo ? dac : (dac & ~bitmask(bitn));
    // busy is still high during the done cycle, which keeps a start there from being accepted
    assign go   = AUTO | (start & ~busy);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            bitn  <= '0;
            code  <= '0;
            ch    <= '0;
            dac   <= '0;
            selb  <= 1'b1;
            sela  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
            joy0  <= '0;
            joy1  <= '0;
            joy2  <= '0;
            joy3  <= '0;
            for (int i = 0; i < 4; i++) shadow[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        state       <= TRIAL;
                        busy        <= 1'b1;
                        ch          <= 2'd0;
                        {selb, sela} <= 2'b00;
                        dac         <= 6'd32;
                        cnt         <= '0;
                        bitn        <= 3'd5;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                TRIAL: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (bitn == 3'd0) begin
                            state <= STORE;
                            code  <= kept;
                            dac   <= '0;
                        end else begin
                            bitn <= bitn - 3'd1;
                            dac  <= kept | bitmask(bitn - 3'd1);
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                STORE: begin
                    // Advance to the next channel; after channel 3 the index wraps back to 0
                    shadow[ch]   <= code;
                    ch           <= ch + 2'd1;
                    {selb, sela} <= ch + 2'd1;
                    dac          <= 6'd32;
                    cnt          <= '0;
                    bitn         <= 3'd5;
                    state        <= TRIAL;
                    if (ch == 2'd3) begin
                        joy0 <= shadow[0];
                        joy1 <= shadow[1];
                        joy2 <= shadow[2];
                        joy3 <= code;
                        done <= 1'b1;
                        if (!AUTO) begin
                            state        <= IDLE;
                            dac          <= '0;
                            {selb, sela} <= 2'b11;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_joy_sar_scan.sv
// Randomized bench for joy_sar_scan with a registered-comparator model and a threshold-based reference.
// Build with JOY_SCAN_AUTO_EN defined to exercise the free-running mode.
module tb_joy_sar_scan;

    localparam int SETTLE = 4;
    localparam int SCAN   = 4 * (6 * SETTLE + 1);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       hilo = 1'b0;
    logic [5:0] dac;
    logic       selb, sela;
    logic [5:0] joy0, joy1, joy2, joy3;
    logic       busy, done;

    int thr [4] = '{40, 0, 63, 32};
    int nvec = 0;
    int nerr = 0;

    joy_sar_scan #(.SETTLE(SETTLE)) dut (
        .clk(clk), .reset(reset), .start(start), .hilo(hilo),
        .dac(dac), .selb(selb), .sela(sela),
        .joy0(joy0), .joy1(joy1), .joy2(joy2), .joy3(joy3),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Comparator: axis voltage above the DAC code, registered one cycle
    always @(posedge clk) hilo <= (thr[{selb, sela}] > int'(dac));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int expv(input int t);
        return (t > 0) ? t - 1 : 0;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dac"}, dac, 0);
        chk({tag, "_sel"}, {selb, sela}, 3);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_joy"}, {joy0, joy1, joy2, joy3}, 0);
    endtask

    task automatic quiet(input int cycles, input string tag);
        int bad = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (done || busy) bad++;
        end
        chk(tag, bad, 0);
    endtask

    task automatic run_scan(input bit rel, input bit mid, input bit seq);
        int k;
        int r;
        int seqv [6];
        logic [5:0] old0;
        r = 0;
        for (int b = 5; b >= 0; b--) begin
            seqv[5-b] = r | (1 << b);
            if (thr[0] > seqv[5-b]) r = seqv[5-b];
        end
        old0 = joy0;
        @(negedge clk);
        if (rel) reset = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        forever begin
            if (seq && k < 6 * SETTLE) begin
                chk($sformatf("seq_dac_c%0d", k), dac, seqv[k / SETTLE]);
                chk($sformatf("seq_sel_c%0d", k), {selb, sela}, 0);
            end
            if (k == 1) chk("busy_after_accept", busy, 1);
            if (k == SCAN - 1) chk("joy_no_partial", joy0, old0);
            if (mid && k == 50) start = 1'b1;
            if (k == 51) start = 1'b0;
            if (done || k >= 2 * SCAN) break;
            @(posedge clk); #1;
            k++;
        end
        chk("done_latency", k, SCAN);
        chk("busy_in_done", busy, 1);
        chk("joy0", joy0, expv(thr[0]));
        chk("joy1", joy1, expv(thr[1]));
        chk("joy2", joy2, expv(thr[2]));
        chk("joy3", joy3, expv(thr[3]));
        @(posedge clk); #1;
        chk("done_width", done, 0);
        chk("busy_after_done", busy, 0);
        chk("idle_sel", {selb, sela}, 3);
    endtask

    initial begin
`ifdef JOY_SCAN_AUTO_EN
        int k;
        int last;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        k = 0;
        last = 0;
        for (int n = 0; n < 3; n++) begin
            start = n[0];
            while (!done && k < 10 * SCAN) begin
                @(posedge clk); #1;
                k++;
            end
            chk("auto_period", k - last, SCAN);
            last = k;
            chk("auto_busy", busy, 1);
            chk("auto_joy0", joy0, expv(thr[0]));
            chk("auto_joy1", joy1, expv(thr[1]));
            chk("auto_joy2", joy2, expv(thr[2]));
            chk("auto_joy3", joy3, expv(thr[3]));
            @(posedge clk); #1;
            k++;
            chk("auto_busy_hold", busy, 1);
        end
`else
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        @(negedge clk);
        reset = 1'b0;
        quiet(40, "idle_no_start");
        chk_reset_vals("idle");

        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        run_scan(1'b1, 1'b0, 1'b1);

        run_scan(1'b0, 1'b1, 1'b0);
        quiet(150, "no_second_scan");

        for (int n = 0; n < 6; n++) begin
            for (int c = 0; c < 4; c++) begin
                case ($urandom_range(0, 5))
                    0: thr[c] = 0;
                    1: thr[c] = 63;
                    default: thr[c] = $urandom_range(0, 63);
                endcase
            end
            run_scan(1'b0, 1'($urandom_range(0, 1)), 1'b1);
        end

        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (59) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("mid_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        quiet(150, "no_done_after_abort");
        chk({26'd0, joy0}, 0, 0);

        thr = '{17, 1, 2, 50};
        run_scan(1'b0, 1'b0, 1'b1);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/joy_sar_scan.md
JOY_SAR_SCAN -- requirements
Module: joy_sar_scan

Interface
REQ-001 Parameter SETTLE, default 4: cycles each DAC trial code is held before the comparator is sampled; legal range 2..255.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  scan request pulse; sampled on clk, accepted only in IDLE.
REQ-005 hilo  input  1  registered comparator result; 1 = selected joystick axis > dac code; one-cycle latency after dac/selb/sela change.
REQ-006 dac  output  6  trial code driven to the 6-bit DAC.
REQ-007 selb  output  1  mux select high bit; {selb,sela} = channel index.
REQ-008 sela  output  1  mux select low bit.
REQ-009 joy0, joy1, joy2, joy3  output  6 each  converted value for channels 0..3.
REQ-010 busy  output  1  high while a scan is in progress.
REQ-011 done  output  1  one-cycle pulse at scan completion.

Function
REQ-012 States SHALL be IDLE, TRIAL, STORE; IDLE->TRIAL on accepted start; TRIAL->STORE after bit 0 of a channel; STORE->TRIAL (next channel) or STORE->IDLE after channel 3.
REQ-013 A scan SHALL convert channels 0,1,2,3 in order, driving {selb,sela} = channel index for the whole channel.
REQ-014 Per channel, SAR SHALL test bits 5 down to 0: trial = partial result OR (1<<bit), held on dac for exactly SETTLE cycles.
REQ-015 hilo SHALL be sampled on the last cycle of each trial window; hilo=1 keeps the bit, hilo=0 clears it.
REQ-016 Resulting code SHALL equal max(v-1,0), where v is the comparator threshold (largest code c with v>c; 0 if none).
REQ-017 STORE SHALL last one cycle, writing the channel result to a shadow register; channel time = 6*SETTLE+1 cycles.
REQ-018 joy0..joy3 SHALL update together from shadow registers in the cycle done is high; no partial scan is ever visible.
REQ-019 done SHALL assert exactly 4*(6*SETTLE+1) cycles after the edge that accepted start (100 cycles at SETTLE=4).
REQ-020 busy SHALL be high from the cycle after start acceptance through the done cycle inclusive, low otherwise.
REQ-021 start while busy SHALL be ignored; no restart, no queuing.
REQ-022 In IDLE, dac SHALL be 0 and {selb,sela} SHALL be 2'b11 (no-sound mux position).
REQ-023 dac, selb, sela, busy, done SHALL be registered outputs.

Reset
REQ-024 reset SHALL asynchronously force state IDLE, dac=0, selb=1, sela=1, joy0..joy3=0, shadow registers=0, busy=0, done=0.
REQ-025 reset mid-scan SHALL abort the scan without done and without updating joy0..joy3 beyond their reset values.
REQ-026 After reset release, the block SHALL accept start on the first rising edge.

Configuration
REQ-027 Macro JOY_SCAN_AUTO_EN defined: scans free-run; first scan begins on the first edge after reset release; each subsequent scan begins in the cycle after done; start is ignored; busy stays high.
REQ-028 JOY_SCAN_AUTO_EN undefined: scans occur only on accepted start per REQ-004/REQ-012.

Verification
REQ-029 Reset asserted then released with no start -> dac=0, selb=1, sela=1, joy0..3=0, busy=0, done=0 indefinitely.
REQ-030 Comparator model thresholds ch0..3 = 40,0,63,32, SETTLE=4, start pulse -> done exactly 100 cycles later; joy0=39, joy1=0, joy2=62, joy3=31.
REQ-031 Threshold 40 on ch0 -> dac sequence 32,48,40,36,38,39, each held exactly 4 cycles, selb=0, sela=0 throughout.
REQ-032 Second start pulse 50 cycles into a scan -> single done at cycle 100; no second scan; busy low after done.
REQ-033 reset asserted 60 cycles into a scan -> immediate reset values, no done pulse, joy0..3 remain 0.
REQ-034 JOY_SCAN_AUTO_EN defined, fixed thresholds -> done pulses every 100 cycles; joy values stable and correct after the first done.
